// File: rtl/sram_cache_controller.sv
// Two-way set-associative, write-through / no-write-allocate read cache that sits
// between the MEM stage and the SRAM controller. Each line holds two 32-bit words.
module sram_cache_controller #(
   parameter int SETS    = 64,
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_rd_en,
   input  logic        mem_wr_en,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        ready,
   output logic        sram_rd_en,
   output logic        sram_wr_en,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   input  logic        sram_ready
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH0 = 2'd1;
   localparam logic [1:0] ST_FETCH1 = 2'd2;
   localparam logic [1:0] ST_WRITE  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [31:0]        buf0_q, buf0_d;
   logic [SETS-1:0]    valid_q [2];
   logic [SETS-1:0]    lru_q;
   logic [TAG_W-1:0]   tag_q   [2][SETS];
   logic [31:0]        word0_q [2][SETS];
   logic [31:0]        word1_q [2][SETS];

   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic               word_sel;
   logic [1:0]         hit_w;
   logic [31:0]        way_word [2];
   logic               hit;
   logic               hit_way;
   logic [31:0]        hit_word;
   logic               victim;
   logic               fill_en;
   logic               wr_upd_en;
   logic               lru_upd_en;
   logic               lru_used_way;
   logic               unused_addr_bits;

   assign index    = mem_address[3 +: INDEX_W];
   assign tag      = mem_address[3 + INDEX_W +: TAG_W];
   assign word_sel = mem_address[2];
   assign unused_addr_bits = &{1'b0, mem_address[1:0]};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_way
         assign hit_w[gi]    = valid_q[gi][index] && (tag_q[gi][index] == tag);
         assign way_word[gi] = word_sel ? word1_q[gi][index] : word0_q[gi][index];

         // Tag and data storage carry no reset; valid bits alone qualify them.
         always_ff @(posedge clk) begin
            if (fill_en && (victim == gi[0])) begin
               tag_q[gi][index]   <= tag;
               word0_q[gi][index] <= buf0_q;
               word1_q[gi][index] <= sram_rdata;
            end else if (wr_upd_en && (hit_way == gi[0])) begin
               if (word_sel) word1_q[gi][index] <= mem_wdata;
               else          word0_q[gi][index] <= mem_wdata;
            end
         end
      end
   endgenerate

   assign hit      = |hit_w;
   assign hit_way  = hit_w[1];
   assign hit_word = way_word[hit_way];

   // Fill empty ways first, then fall back to the least-recently-used one.
   assign victim = !valid_q[0][index] ? 1'b0 :
                   !valid_q[1][index] ? 1'b1 : lru_q[index];

   always_comb begin
      state_d      = state_q;
      buf0_d       = buf0_q;
      ready        = 1'b0;
      mem_rdata    = 32'h0;
      sram_rd_en   = 1'b0;
      sram_wr_en   = 1'b0;
      sram_address = 32'h0;
      sram_wdata   = 32'h0;
      fill_en      = 1'b0;
      wr_upd_en    = 1'b0;
      lru_upd_en   = 1'b0;
      lru_used_way = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_wr_en) begin
               state_d = ST_WRITE;
            end else if (mem_rd_en) begin
               if (hit) begin
                  ready        = 1'b1;
                  mem_rdata    = hit_word;
                  lru_upd_en   = 1'b1;
                  lru_used_way = hit_way;
               end else begin
                  state_d = ST_FETCH0;
               end
            end else begin
               ready = 1'b1;
            end
         end
         ST_FETCH0: begin
            sram_rd_en   = 1'b1;
            sram_address = {mem_address[31:3], 3'b000};
            if (sram_ready) begin
               buf0_d  = sram_rdata;
               state_d = ST_FETCH1;
            end
         end
         ST_FETCH1: begin
            sram_rd_en   = 1'b1;
            sram_address = {mem_address[31:3], 3'b100};
            if (sram_ready) begin
               fill_en      = 1'b1;
               lru_upd_en   = 1'b1;
               lru_used_way = victim;
               ready        = 1'b1;
               mem_rdata    = word_sel ? sram_rdata : buf0_q;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            sram_wr_en   = 1'b1;
            sram_address = {mem_address[31:2], 2'b00};
            sram_wdata   = mem_wdata;
            if (sram_ready) begin
               ready   = 1'b1;
               state_d = ST_IDLE;
               if (hit) begin
                  wr_upd_en    = 1'b1;
                  lru_upd_en   = 1'b1;
                  lru_used_way = hit_way;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         buf0_q     <= 32'h0;
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         lru_q      <= '0;
      end else begin
         state_q <= state_d;
         buf0_q  <= buf0_d;
         if (fill_en) valid_q[victim][index] <= 1'b1;
         if (lru_upd_en) lru_q[index] <= ~lru_used_way;
      end
   end

endmodule

// File: tb/tb_sram_cache_controller.sv
// Directed bench for sram_cache_controller with a behavioural SRAM controller
// (6-cycle reads, 3-cycle writes) so miss/write latencies match the real one.
module tb_sram_cache_controller;

   localparam int RLAT = 6;
   localparam int WLAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_rd_en = 1'b0;
   logic        mem_wr_en = 1'b0;
   logic [31:0] mem_address = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [31:0] mem_rdata;
   logic        ready;
   logic        sram_rd_en;
   logic        sram_wr_en;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_ready;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   sram_cache_controller #(.SETS(64), .INDEX_W(6), .TAG_W(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_rd_en    (mem_rd_en),
      .mem_wr_en    (mem_wr_en),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .ready        (ready),
      .sram_rd_en   (sram_rd_en),
      .sram_wr_en   (sram_wr_en),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready)
   );

   // Behavioural SRAM controller: ready in the last cycle of each access.
   logic [31:0] sram_mem [0:2047];
   logic [31:0] rd_log [$];
   int          wr_total = 0;
   int          cnt = 0;

   assign sram_ready = (sram_rd_en && cnt == RLAT - 1) || (sram_wr_en && cnt == WLAT - 1);
   assign sram_rdata = sram_rd_en ? sram_mem[sram_address[12:2]] : 32'h0;

   always @(posedge clk) begin
      if (sram_rd_en || sram_wr_en) cnt <= sram_ready ? 0 : cnt + 1;
      else                          cnt <= 0;
      if (sram_wr_en && sram_ready) begin
         sram_mem[sram_address[12:2]] <= sram_wdata;
         wr_total <= wr_total + 1;
      end
      if (sram_rd_en && sram_ready) rd_log.push_back(sram_address);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Issues one request at cycle 0 and checks latency, returned data and SRAM traffic.
   task automatic run_req(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input int exp_rd_n, input int exp_wr_n);
      int          lat;
      bit          done;
      int          rd_base;
      int          wr_base;
      logic [31:0] got;
      rd_base     = rd_log.size();
      wr_base     = wr_total;
      mem_rd_en   = rd;
      mem_wr_en   = wr;
      mem_address = addr;
      mem_wdata   = wd;
      lat  = 0;
      done = 0;
      got  = 32'hx;
      while (!done && lat < 40) begin
         @(negedge clk);
         if (ready) begin
            done = 1;
            got  = mem_rdata;
         end else begin
            lat++;
         end
      end
      check({name, ":latency"}, 32'(lat), 32'(exp_lat));
      check({name, ":rdata"}, got, exp_rdata);
      @(posedge clk);
      #1;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      check({name, ":sram_reads"}, 32'(rd_log.size() - rd_base), 32'(exp_rd_n));
      check({name, ":sram_writes"}, 32'(wr_total - wr_base), 32'(exp_wr_n));
      if (exp_rd_n == 2 && rd_log.size() - rd_base == 2) begin
         check({name, ":rd_addr0"}, rd_log[rd_base],     {addr[31:3], 3'b000});
         check({name, ":rd_addr1"}, rd_log[rd_base + 1], {addr[31:3], 3'b100});
      end
      $display("txn %-10s rd=%0b wr=%0b addr=0x%08h lat=%0d rdata=0x%08h", name, rd, wr, addr, lat, got);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) sram_mem[i] = 32'hC000_0000 | (i << 2);
      sram_mem[32'h10 >> 2] = 32'hAAAA_5555;

      #2;
      check("reset:ready",      {31'h0, ready},      32'h1);
      check("reset:sram_rd_en", {31'h0, sram_rd_en}, 32'h0);
      check("reset:sram_wr_en", {31'h0, sram_wr_en}, 32'h0);
      check("reset:mem_rdata",  mem_rdata,           32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Cold miss, then hits on both words of the line.
      run_req("miss010",  1, 0, 32'h010, 32'h0, 12, 32'hAAAA_5555, 2, 0);
      run_req("hit010",   1, 0, 32'h010, 32'h0,  0, 32'hAAAA_5555, 0, 0);
      run_req("hit014",   1, 0, 32'h014, 32'h0,  0, 32'hC000_0014, 0, 0);

      // Write-through hit updates the cached word.
      run_req("wr014",    0, 1, 32'h014, 32'hDEAD_BEEF, 3, 32'h0, 0, 1);
      run_req("rd014",    1, 0, 32'h014, 32'h0,  0, 32'hDEAD_BEEF, 0, 0);

      // Write miss allocates nothing; the following read misses and sees SRAM data.
      run_req("wr100",    0, 1, 32'h100, 32'h1234_5678, 3, 32'h0, 0, 1);
      run_req("rd100",    1, 0, 32'h100, 32'h0, 12, 32'h1234_5678, 2, 0);

      // Index 2: third distinct tag evicts the LRU line (0x010).
      run_req("miss210",  1, 0, 32'h210, 32'h0, 12, 32'hC000_0210, 2, 0);
      run_req("miss410",  1, 0, 32'h410, 32'h0, 12, 32'hC000_0410, 2, 0);
      run_req("hit210",   1, 0, 32'h210, 32'h0,  0, 32'hC000_0210, 0, 0);
      run_req("evict010", 1, 0, 32'h010, 32'h0, 12, 32'hAAAA_5555, 2, 0);

      // A hit on 0x210 then on 0x010 must leave 0x210 as the victim for 0x610.
      run_req("hit210b",  1, 0, 32'h210, 32'h0,  0, 32'hC000_0210, 0, 0);
      run_req("hit010b",  1, 0, 32'h010, 32'h0,  0, 32'hAAAA_5555, 0, 0);
      run_req("miss610",  1, 0, 32'h610, 32'h0, 12, 32'hC000_0610, 2, 0);
      run_req("hit010c",  1, 0, 32'h010, 32'h0,  0, 32'hAAAA_5555, 0, 0);
      run_req("evict210", 1, 0, 32'h210, 32'h0, 12, 32'hC000_0210, 2, 0);

      // Simultaneous read and write: the write wins and no data is returned.
      run_req("rdwr018",  1, 1, 32'h018, 32'h0BAD_F00D, 3, 32'h0, 0, 1);
      run_req("rd018",    1, 0, 32'h018, 32'h0, 12, 32'h0BAD_F00D, 2, 0);

      // Reset pulsed during FETCH1 drops the SRAM read immediately.
      mem_rd_en   = 1'b1;
      mem_address = 32'h020;
      repeat (9) @(negedge clk);
      check("rstmid:rd_en_before", {31'h0, sram_rd_en}, 32'h1);
      check("rstmid:addr_before",  sram_address,        32'h024);
      #1;
      rst = 1'b0;
      #1;
      check("rstmid:rd_en_after",  {31'h0, sram_rd_en}, 32'h0);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      mem_rd_en = 1'b0;
      $display("txn rstmid     reset pulsed during fetch of addr=0x00000020");

      run_req("rd020",    1, 0, 32'h020, 32'h0, 12, 32'hC000_0020, 2, 0);
      run_req("rd010post",1, 0, 32'h010, 32'h0, 12, 32'hAAAA_5555, 2, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
